// File: rtl/nn_pkg.sv
// ---------------------------------------------------------------------------
// nn_pkg
// Shared types and helpers for the shared-serializer scheduler.
//   state_t  : scheduler FSM states (idle / load vector / wait for beats).
//   rr_pick  : round-robin winner search over a request vector, starting at a
//              priority pointer and wrapping modulo n. Returns -1 when no
//              request is asserted.
// ---------------------------------------------------------------------------
package nn_pkg;

    typedef enum logic [1:0] {
        s_IDLE = 2'd0,
        s_LOAD = 2'd1,
        s_WAIT = 2'd2
    } state_t;

    // Widest request vector the helper accepts; callers zero-extend.
    localparam int MAX_REQ   = 32;
    localparam int MAX_REQ_W = 5;

    function automatic int rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input int                 n,
        input int                 ptr
    );
        int idx;
        int pick;
        pick = -1;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                // ptr < n, so a single conditional subtract implements the wrap
                idx = ptr + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (pick < 0 && valid[idx[MAX_REQ_W-1:0]]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/serializer_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at i_ptr and wraps, so
// the requester at the pointer has highest priority.
// Ports:
//   i_req   : request vector, one bit per requester
//   i_ptr   : priority pointer (index searched first)
//   o_any   : at least one request asserted
//   o_grant : one-hot grant (zero when o_any is low)
//   o_idx   : encoded index of the winner (zero when o_any is low)
// ---------------------------------------------------------------------------
module rr_arbiter
    import nn_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SRC_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [SRC_W-1:0] i_ptr,
    output logic             o_any,
    output logic [N_REQ-1:0] o_grant,
    output logic [SRC_W-1:0] o_idx
);

    logic [MAX_REQ-1:0] req_ext;
    int                 pick;

    always_comb begin
        req_ext            = '0;
        req_ext[N_REQ-1:0] = i_req;
        pick               = rr_pick(req_ext, N_REQ, int'(i_ptr));
    end

    assign o_any = (pick >= 0);
    assign o_idx = o_any ? pick[SRC_W-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign o_grant[gi] = o_any && (int'(o_idx) == gi);
        end
    endgenerate

endmodule

// File: rtl/serializer_arbiter.sv
// ---------------------------------------------------------------------------
// serializer_arbiter
// Round-robin scheduler that shares one parallel-to-serial serializer among
// N_REQ vector producers. One producer is granted at a time; its vector is
// handed to the serializer and the grant is held until the serializer has
// emitted all N_PARALLEL beats downstream. o_src_id tags the serial stream.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_req_data     : N_REQ concatenated vectors, source k in slice k
//   i_req_valid    : per-source valid
//   o_req_ready    : per-source ready, one-hot or zero
//   o_ser_data     : granted vector to the serializer
//   o_ser_valid    : valid to the serializer
//   i_ser_ready    : ready from the serializer
//   i_ser_beat     : one serial beat accepted downstream
//   o_src_id       : source currently being serialized
//   o_busy         : a grant is held
// ---------------------------------------------------------------------------
module serializer_arbiter
    import nn_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int N_PARALLEL = 30,
    parameter int DATA_WIDTH = 16,
    parameter int SRC_W      = $clog2(N_REQ)
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic [N_REQ*N_PARALLEL*DATA_WIDTH-1:0] i_req_data,
    input  logic [N_REQ-1:0]                      i_req_valid,
    output logic [N_REQ-1:0]                      o_req_ready,
    output logic [N_PARALLEL*DATA_WIDTH-1:0]      o_ser_data,
    output logic                                  o_ser_valid,
    input  logic                                  i_ser_ready,
    input  logic                                  i_ser_beat,
    output logic [SRC_W-1:0]                      o_src_id,
    output logic                                  o_busy
);

    localparam int               VEC_W     = N_PARALLEL * DATA_WIDTH;
    localparam int               CNT_W     = (N_PARALLEL > 1) ? $clog2(N_PARALLEL) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_PARALLEL - 1);
    localparam logic [SRC_W-1:0] LAST_SRC  = SRC_W'(N_REQ - 1);

    state_t           state_q,    state_d;
    logic [SRC_W-1:0] grant_q,    grant_d;
    logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
    logic [SRC_W-1:0] ptr_q,      ptr_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    logic             arb_any;
    logic [N_REQ-1:0] arb_grant;
    logic [SRC_W-1:0] arb_idx;

    logic [VEC_W-1:0] slice [N_REQ];
    logic             grant_valid;
    logic             handshake;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_rr_arbiter (
        .i_req   (i_req_valid),
        .i_ptr   (ptr_q),
        .o_any   (arb_any),
        .o_grant (arb_grant),
        .o_idx   (arb_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign slice[gi] = i_req_data[gi*VEC_W +: VEC_W];
        end
    endgenerate

    // Vector path is a plain mux on the registered grant so the serializer
    // sees stable data for as long as it stalls.
    assign grant_valid = i_req_valid[grant_q];
    assign o_ser_data  = slice[grant_q];
    assign o_ser_valid = (state_q == s_LOAD) && grant_valid;
    // Producer ready mirrors serializer ready so both sides transfer together.
    assign o_req_ready = ((state_q == s_LOAD) && i_ser_ready) ? grant_oh_q : '0;
    assign handshake   = o_ser_valid && i_ser_ready;
    assign o_src_id    = grant_q;
    assign o_busy      = (state_q != s_IDLE);

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            s_IDLE: begin
                if (arb_any) begin
                    grant_d    = arb_idx;
                    grant_oh_d = arb_grant;
                    state_d    = s_LOAD;
                end
            end
            s_LOAD: begin
                if (handshake) begin
                    state_d = s_WAIT;
                    cnt_d   = '0;
                end else if (!grant_valid) begin
                    // Producer withdrew its vector: give up the grant without
                    // advancing the pointer, so it keeps its priority.
                    state_d = s_IDLE;
                end
            end
            s_WAIT: begin
                if (i_ser_beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = s_IDLE;
                        cnt_d   = '0;
                        ptr_d   = (grant_q == LAST_SRC) ? '0 : grant_q + SRC_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = s_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= s_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_serializer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_serializer_arbiter
// Directed scenarios followed by randomized rounds. Inputs change just after
// the falling edge; outputs are checked 1 time unit later, well before the
// next rising edge. The expected winner is computed from the pending request
// set by a plain modular scan from the bench's own priority pointer.
// ---------------------------------------------------------------------------
module tb_serializer_arbiter;

    localparam int N_REQ      = 4;
    localparam int N_PARALLEL = 4;
    localparam int DATA_WIDTH = 16;
    localparam int SRC_W      = 2;
    localparam int VEC_W      = N_PARALLEL * DATA_WIDTH;

    logic                            i_clk = 1'b0;
    logic                            i_reset = 1'b1;
    logic [N_REQ-1:0][VEC_W-1:0]     data;
    logic [N_REQ-1:0]                i_req_valid = '0;
    logic [N_REQ-1:0]                o_req_ready;
    logic [VEC_W-1:0]                o_ser_data;
    logic                            o_ser_valid;
    logic                            i_ser_ready = 1'b0;
    logic                            i_ser_beat = 1'b0;
    logic [SRC_W-1:0]                o_src_id;
    logic                            o_busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    serializer_arbiter #(
        .N_REQ      (N_REQ),
        .N_PARALLEL (N_PARALLEL),
        .DATA_WIDTH (DATA_WIDTH),
        .SRC_W      (SRC_W)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_data  (data),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .o_ser_data  (o_ser_data),
        .o_ser_valid (o_ser_valid),
        .i_ser_ready (i_ser_ready),
        .i_ser_beat  (i_ser_beat),
        .o_src_id    (o_src_id),
        .o_busy      (o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset     = 1'b1;
        i_req_valid = '0;
        i_ser_ready = 1'b0;
        i_ser_beat  = 1'b0;
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    // Full transaction for one producer: valids are already driven and the
    // scheduler is idle. Stalls the serializer, handshakes once, then emits
    // nbeats serial beats with random gaps. Producer drops valid after transfer.
    task automatic serve(input int exp_src, input int stall, input int nbeats);
        int               waited;
        logic [VEC_W-1:0] held;
        i_ser_ready = 1'b0;
        waited = 0;
        while (o_ser_valid !== 1'b1 && waited < 8) begin
            @(negedge i_clk); #1;
            waited++;
        end
        chk("req_to_valid_latency", 64'(waited), 64'd1);
        chk("src_id", 64'(o_src_id), 64'(exp_src));
        chk("ser_data", o_ser_data, data[exp_src]);
        chk("ready_before_hs", 64'(o_req_ready), 64'd0);
        held = o_ser_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge i_clk); #1;
            chk("stall_valid", 64'(o_ser_valid), 64'd1);
            chk("stall_data", o_ser_data, held);
            chk("stall_ready", 64'(o_req_ready), 64'd0);
        end
        @(negedge i_clk);
        i_ser_ready = 1'b1;
        #1;
        chk("req_ready_onehot", 64'(o_req_ready), 64'(1) << exp_src);
        @(negedge i_clk);
        i_ser_ready = 1'b0;
        i_req_valid[exp_src[1:0]] = 1'b0;
        #1;
        chk("wait_outputs", 64'({o_ser_valid, o_req_ready, o_busy}), 64'b000001);
        for (int b = 0; b < nbeats; b++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge i_clk);
                i_ser_beat = 1'b0;
                #1;
                chk("busy_gap", 64'(o_busy), 64'd1);
            end
            @(negedge i_clk);
            i_ser_beat = 1'b1;
            #1;
            chk("busy_beat", 64'(o_busy), 64'd1);
        end
        if (nbeats == N_PARALLEL) begin
            @(negedge i_clk);
            i_ser_beat = 1'b0;
            #1;
            chk("busy_after_last", 64'(o_busy), 64'd0);
            chk("src_id_held", 64'(o_src_id), 64'(exp_src));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               n_pulse;
        int               last_cyc;
        int               ptr_m;
        int               exp_w;
        int               w;
        logic [N_REQ-1:0] pend;

        data = '0;

        // Reset then idle with no requests
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_clk); #1;
            chk("idle_outputs", 64'({o_req_ready, o_ser_valid, o_src_id, o_busy}), 64'd0);
        end

        // Single source 2 with serializer always ready
        @(negedge i_clk);
        data[2]     = 64'h0004_0003_0002_0001;
        i_ser_ready = 1'b1;
        i_req_valid = 4'b0100;
        #1;
        chk("s2_valid_not_yet", 64'(o_ser_valid), 64'd0);
        @(negedge i_clk); #1;
        chk("s2_ser_valid", 64'(o_ser_valid), 64'd1);
        chk("s2_req_ready", 64'(o_req_ready), 64'b0100);
        chk("s2_src_id", 64'(o_src_id), 64'd2);
        chk("s2_ser_data", o_ser_data, 64'h0004_0003_0002_0001);
        @(negedge i_clk);
        i_req_valid = '0;
        i_ser_ready = 1'b0;
        #1;
        chk("s2_ready_once", 64'(o_req_ready), 64'd0);
        for (int b = 0; b < N_PARALLEL; b++) begin
            @(negedge i_clk);
            i_ser_beat = 1'b1;
            #1;
            chk("s2_busy_during_beats", 64'(o_busy), 64'd1);
        end
        @(negedge i_clk);
        i_ser_beat = 1'b0;
        #1;
        chk("s2_busy_fall", 64'(o_busy), 64'd0);
        chk("s2_src_id_held", 64'(o_src_id), 64'd2);
        // Pointer should now sit at 3: sources 1 and 3 both asking -> 3 wins
        data[1] = 64'h1111_2222_3333_4444;
        data[3] = 64'h9999_8888_7777_6666;
        i_req_valid = 4'b1010;
        serve(3, 0, N_PARALLEL);
        serve(1, 0, N_PARALLEL);

        // All sources requesting continuously, back-to-back beats
        do_reset();
        i_req_valid = 4'hF;
        i_ser_ready = 1'b1;
        i_ser_beat  = 1'b1;
        n_pulse  = 0;
        last_cyc = 0;
        for (int c = 0; c < 80 && n_pulse < 5; c++) begin
            @(negedge i_clk); #1;
            if (o_req_ready != '0) begin
                chk("rr_order", 64'(o_req_ready), 64'(1) << (n_pulse % N_REQ));
                if (n_pulse > 0) begin
                    chk("rr_spacing", 64'(c - last_cyc), 64'(N_PARALLEL + 2));
                end
                last_cyc = c;
                n_pulse++;
            end
        end
        chk("rr_pulse_count", 64'(n_pulse), 64'd5);

        // Source 1 with serializer stalled 5 cycles
        do_reset();
        data[1]     = 64'hDEAD_BEEF_CAFE_F00D;
        i_req_valid = 4'b0010;
        serve(1, 5, N_PARALLEL);

        // Source 0 withdraws its request before the serializer is ready
        do_reset();
        i_req_valid = 4'b0001;
        @(negedge i_clk); #1;
        chk("drop_load_valid", 64'(o_ser_valid), 64'd1);
        @(negedge i_clk);
        i_req_valid = '0;
        #1;
        chk("drop_no_ready", 64'({o_ser_valid, o_req_ready}), 64'd0);
        @(negedge i_clk); #1;
        chk("drop_idle", 64'(o_busy), 64'd0);
        i_req_valid = 4'b0011;
        serve(0, 1, N_PARALLEL);

        // Reset in the middle of a transfer (pointer is 1 here)
        data[2]     = 64'h0A0B_0C0D_0E0F_1011;
        i_req_valid = 4'b0100;
        serve(2, 0, 2);
        @(negedge i_clk);
        i_ser_beat = 1'b0;
        i_reset    = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        chk("rst_mid_outputs", 64'({o_req_ready, o_ser_valid, o_src_id, o_busy}), 64'd0);
        i_req_valid = 4'b1001;
        serve(0, 0, N_PARALLEL);
        serve(3, 0, N_PARALLEL);

        // Randomized rounds against the round-robin model
        do_reset();
        ptr_m = 0;
        pend  = '0;
        for (int r = 0; r < 24; r++) begin
            for (int k = 0; k < N_REQ; k++) begin
                data[k] = {$urandom, $urandom};
            end
            pend = pend | 4'($urandom_range(0, 15));
            if (pend == '0) begin
                pend[$urandom_range(0, 3)] = 1'b1;
            end
            exp_w = -1;
            for (int i = 0; i < N_REQ; i++) begin
                w = (ptr_m + i) % N_REQ;
                if (exp_w < 0 && pend[w]) begin
                    exp_w = w;
                end
            end
            i_req_valid = pend;
            serve(exp_w, $urandom_range(0, 3), N_PARALLEL);
            pend[exp_w] = 1'b0;
            ptr_m = (exp_w + 1) % N_REQ;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serializer_arbiter.md
Name: serializer_arbiter

Overview:
- Round-robin scheduler sharing one parallel-to-serial serializer between N_REQ vector producers, e.g. neuron layer outputs.
- Grants one producer at a time and forwards its N_PARALLEL-word vector to the serializer's slave AXI-stream port.
- Holds the grant until the serializer has emitted all N_PARALLEL beats downstream.
- Presents the granted source index as a tag so the consumer knows which producer the serial stream belongs to.

Parameters:
- N_REQ, 4: number of requesting producers, at least 2.
- N_PARALLEL, 30: words per vector; must match the serializer.
- DATA_WIDTH, 16: bits per word.
- SRC_W, $clog2(N_REQ): width of the source tag.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_req_data  in  N_REQ*N_PARALLEL*DATA_WIDTH  concatenated vectors; source k occupies slice k.
- i_req_valid  in  N_REQ  per-source valid.
- o_req_ready  out  N_REQ  per-source ready; one-hot or zero.
- o_ser_data  out  N_PARALLEL*DATA_WIDTH  vector to serializer i_data.
- o_ser_valid  out  1  to serializer i_valid.
- i_ser_ready  in  1  from serializer o_ready.
- i_ser_beat  in  1  serializer output beat accepted downstream (serializer o_valid AND consumer ready).
- o_src_id  out  SRC_W  source currently being serialized.
- o_busy  out  1  high while a grant is held.

Behaviour:
- Reset: state s_IDLE, grant 0, priority pointer 0, beat counter 0. Outputs: o_req_ready=0, o_ser_valid=0, o_src_id=0, o_busy=0. Reset mid-transfer abandons the transfer immediately; the serializer is reset by the same i_reset.
- FSM s_IDLE:
  - Scan i_req_valid starting at the priority pointer and wrapping modulo N_REQ.
  - First asserted source k: register grant=k, o_src_id=k, go s_LOAD.
  - No request: stay. Arbitration costs 1 cycle.
- FSM s_LOAD:
  - o_ser_valid = i_req_valid[grant] (combinational). o_ser_data = slice[grant] (combinational mux on the registered grant).
  - o_req_ready[grant] = i_ser_ready (combinational); all other bits 0.
  - Handshake (o_ser_valid & i_ser_ready): producer and serializer transfer the vector in the same cycle; next state s_WAIT; beat counter cleared.
  - If i_req_valid[grant] drops before the handshake (protocol violation): return to s_IDLE, pointer unchanged, no beats counted.
- FSM s_WAIT:
  - o_ser_valid=0, o_req_ready=0.
  - Each i_ser_beat increments the counter.
  - Beat with counter==N_PARALLEL-1: go s_IDLE, pointer=(grant+1) mod N_REQ, counter=0.
  - i_ser_beat outside s_WAIT is ignored.
- o_busy = (state != s_IDLE). o_src_id holds the registered grant until the next grant.
- Fairness: a source re-requesting immediately waits for every other pending source. With all sources active, each gets exactly one vector per N_REQ grants.
- Latency: request to o_ser_valid is 1 cycle from s_IDLE. Last beat to the next o_ser_valid is 2 cycles (s_WAIT→s_IDLE, s_IDLE→s_LOAD).
- Counter width $clog2(N_PARALLEL); when N_PARALLEL is a power of two, the counter does not wrap before the compare.

Decomposition:
- Package nn_pkg: state typedef {s_IDLE, s_LOAD, s_WAIT}, and a function computing the round-robin winner from (valid vector, pointer).
- One natural sub-module: rr_arbiter (combinational priority-rotate, N_REQ parameter). Outputs a one-hot grant and the encoded index; reusable by other shared resources.

Test Plan (N_REQ=4, N_PARALLEL=4, DATA_WIDTH=16):
- Reset then idle, no valids → all outputs 0 for 10 cycles; o_busy=0.
- Only source 2 valid, vector 0x0004_0003_0002_0001; i_ser_ready=1; four i_ser_beat pulses → o_ser_valid one cycle after valid; o_req_ready=4'b0100 exactly one cycle; o_src_id=2; o_busy falls after the 4th beat; pointer=3.
- All four valid continuously; i_ser_ready=1, beats back-to-back → grant order 0,1,2,3,0; each o_req_ready pulse separated by 4 beats + 2 cycles.
- Source 1 valid, i_ser_ready low for 5 cycles → o_ser_valid held with stable o_ser_data; o_req_ready stays 0 until i_ser_ready rises; single handshake.
- Source 0 valid in s_LOAD, then valid drops before ready → return to s_IDLE, no o_req_ready pulse; pointer stays 0; source 0 is regranted on re-request.
- i_reset asserted after 2 of 4 beats → next cycle s_IDLE, o_busy=0, counter 0. A fresh request from source 3 is granted (pointer reset to 0, scan reaches 3).
